// File: rtl/raster_timing_gen.sv
// Raster timing generator: pixel/line counters with registered sync, display
// enable, line/frame pulses, a frame counter and a sticky raster-line interrupt.
module raster_timing_gen #(
  parameter int H_ACTIVE = 403,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 48,
  parameter int H_BP     = 40,
  parameter int V_ACTIVE = 284,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 24,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CW       = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_enable,
  input  logic [CW-1:0] i_irq_line,
  input  logic          i_irq_ack,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_de,
  output logic [CW-1:0] o_x,
  output logic [CW-1:0] o_y,
  output logic          o_line_start,
  output logic          o_frame_start,
  output logic          o_irq,
  output logic [7:0]    o_frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Back porches of at least one keep every boundary below the total, so all fit in CW bits.
  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_DE_END   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_DE_END   = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END     = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END     = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] x_reg, y_reg;
  logic [CW-1:0] x_next, y_next;
  logic          hsync_reg, vsync_reg, de_reg;
  logic          line_start_reg, frame_start_reg, irq_reg;
  logic [7:0]    frame_count_reg;
  logic          at_line_end, at_frame_end, irq_hit;
  logic          de_next, hsync_next, vsync_next;

  // Decode from the next coordinates so sync/enable land together with o_x/o_y.
  always_comb begin
    at_line_end  = (x_reg == H_LAST);
    at_frame_end = at_line_end && (y_reg == V_LAST);
    x_next       = at_line_end ? '0 : x_reg + CW'(1);
    y_next       = y_reg;
    if (at_line_end)
      y_next = (y_reg == V_LAST) ? '0 : y_reg + CW'(1);
    de_next    = (x_next < H_DE_END) && (y_next < V_DE_END);
    hsync_next = ((x_next >= HS_START) && (x_next < HS_END)) ? H_POL : ~H_POL;
    vsync_next = ((y_next >= VS_START) && (y_next < VS_END)) ? V_POL : ~V_POL;
    // An out-of-range compare line can never equal y_next, so it never fires.
    irq_hit    = at_line_end && (y_next == i_irq_line);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_reg           <= H_LAST;
      y_reg           <= V_LAST;
      de_reg          <= 1'b0;
      hsync_reg       <= ~H_POL;
      vsync_reg       <= ~V_POL;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      irq_reg         <= 1'b0;
      frame_count_reg <= 8'd0;
    end else begin
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      if (i_enable) begin
        x_reg           <= x_next;
        y_reg           <= y_next;
        de_reg          <= de_next;
        hsync_reg       <= hsync_next;
        vsync_reg       <= vsync_next;
        line_start_reg  <= at_line_end;
        frame_start_reg <= at_frame_end;
        if (at_frame_end)
          frame_count_reg <= frame_count_reg + 8'd1;
      end
      // Set wins over a simultaneous acknowledge.
      irq_reg <= (i_enable && irq_hit) || (irq_reg && !i_irq_ack);
    end
  end

  assign o_x           = x_reg;
  assign o_y           = y_reg;
  assign o_de          = de_reg;
  assign o_hsync       = hsync_reg;
  assign o_vsync       = vsync_reg;
  assign o_line_start  = line_start_reg;
  assign o_frame_start = frame_start_reg;
  assign o_irq         = irq_reg;
  assign o_frame_count = frame_count_reg;

endmodule

// File: tb/tb_raster_timing_gen.sv
// Directed bench for raster_timing_gen on a tiny 8x6 raster (H 4/1/2/1, V 3/1/1/1).
module tb_raster_timing_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_enable;
  logic [3:0] i_irq_line;
  logic       i_irq_ack;
  logic       o_hsync, o_vsync, o_de, o_line_start, o_frame_start, o_irq;
  logic [3:0] o_x, o_y;
  logic [7:0] o_frame_count;

  int errors = 0;
  int checks = 0;
  int de_cnt, hs_cnt, hs_pos_cnt, vs_cnt, vs_line_cnt, fs_cnt, ls_cnt, irq_cnt;
  int ex, ey;

  raster_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .CW(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_enable(i_enable),
    .i_irq_line(i_irq_line),
    .i_irq_ack(i_irq_ack),
    .o_hsync(o_hsync),
    .o_vsync(o_vsync),
    .o_de(o_de),
    .o_x(o_x),
    .o_y(o_y),
    .o_line_start(o_line_start),
    .o_frame_start(o_frame_start),
    .o_irq(o_irq),
    .o_frame_count(o_frame_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Outputs are sampled on the falling edge, away from the active edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_x"},  32'(o_x), 7);
    check({tag, "_y"},  32'(o_y), 5);
    check({tag, "_de"}, 32'(o_de), 0);
    check({tag, "_hs"}, 32'(o_hsync), 1);
    check({tag, "_vs"}, 32'(o_vsync), 1);
    check({tag, "_ls"}, 32'(o_line_start), 0);
    check({tag, "_fs"}, 32'(o_frame_start), 0);
    check({tag, "_irq"}, 32'(o_irq), 0);
    check({tag, "_fc"}, 32'(o_frame_count), 0);
  endtask

  task automatic tally();
    if (o_de) de_cnt++;
    if (!o_hsync) hs_cnt++;
    if (!o_hsync && (o_x == 4'd5 || o_x == 4'd6)) hs_pos_cnt++;
    if (!o_vsync) vs_cnt++;
    if (!o_vsync && o_y == 4'd4) vs_line_cnt++;
    if (o_line_start) ls_cnt++;
  endtask

  initial begin
    reset      = 1'b1;
    i_enable   = 1'b1;
    i_irq_line = 4'd7;
    i_irq_ack  = 1'b0;

    // Reset state
    step(1);
    check_reset_values("rst");

    // First enabled edge after release lands on (0,0) with both pulses
    reset = 1'b0;
    step(1);
    check("first_x", 32'(o_x), 0);
    check("first_y", 32'(o_y), 0);
    check("first_fs", 32'(o_frame_start), 1);
    check("first_ls", 32'(o_line_start), 1);
    check("first_fc", 32'(o_frame_count), 1);
    check("first_de", 32'(o_de), 1);

    // One full 48-clk frame: coordinates, sync windows and enable area
    de_cnt = 0; hs_cnt = 0; hs_pos_cnt = 0; vs_cnt = 0; vs_line_cnt = 0; ls_cnt = 0; fs_cnt = 0;
    ex = 0; ey = 0;
    tally();
    for (int i = 1; i < 48; i++) begin
      step(1);
      ex = ex + 1;
      if (ex == 8) begin ex = 0; ey = ey + 1; end
      check("walk_x", 32'(o_x), 32'(ex));
      check("walk_y", 32'(o_y), 32'(ey));
      if (o_frame_start) fs_cnt++;
      tally();
    end
    check("frame_de_cnt", 32'(de_cnt), 12);
    check("frame_hs_cnt", 32'(hs_cnt), 12);
    check("frame_hs_pos", 32'(hs_pos_cnt), 12);
    check("frame_vs_cnt", 32'(vs_cnt), 8);
    check("frame_vs_line", 32'(vs_line_cnt), 8);
    check("frame_ls_cnt", 32'(ls_cnt), 6);
    check("frame_fs_mid", 32'(fs_cnt), 0);
    step(1);
    check("frame2_fs", 32'(o_frame_start), 1);
    check("frame2_xy", 32'({o_x, o_y}), 0);
    check("frame2_fc", 32'(o_frame_count), 2);

    // Alternate enable: 96-clk frame, pulses stay one clk wide
    fs_cnt = 0; ls_cnt = 0;
    for (int i = 1; i <= 96; i++) begin
      i_enable = (i % 2 == 0);
      step(1);
      if (i == 1) begin
        check("hold_xy", 32'({o_x, o_y}), 0);
        check("hold_fs", 32'(o_frame_start), 0);
        check("hold_ls", 32'(o_line_start), 0);
      end
      if (o_frame_start) fs_cnt++;
      if (o_line_start) ls_cnt++;
    end
    i_enable = 1'b1;
    check("tog_fs_cnt", 32'(fs_cnt), 1);
    check("tog_ls_cnt", 32'(ls_cnt), 6);
    check("tog_end_fs", 32'(o_frame_start), 1);
    check("tog_end_xy", 32'({o_x, o_y}), 0);
    check("tog_fc", 32'(o_frame_count), 3);

    // Raster interrupt on line 2, sticky until acknowledged
    i_irq_line = 4'd2;
    step(15);
    check("irq_pre_x", 32'(o_x), 7);
    check("irq_pre", 32'(o_irq), 0);
    step(1);
    check("irq_set_y", 32'(o_y), 2);
    check("irq_set", 32'(o_irq), 1);
    step(5);
    check("irq_sticky", 32'(o_irq), 1);
    i_irq_ack = 1'b1;
    step(1);
    i_irq_ack = 1'b0;
    check("irq_ack_clr", 32'(o_irq), 0);
    step(41);
    check("irq_pre2_xy", 32'({o_x, o_y}), 32'({4'd7, 4'd1}));
    check("irq_pre2", 32'(o_irq), 0);
    check("irq_pre2_fc", 32'(o_frame_count), 4);
    // Acknowledge coincides with the set edge, then persists one more clk
    i_irq_ack = 1'b1;
    step(1);
    check("irq_prio", 32'(o_irq), 1);
    check("irq_prio_y", 32'(o_y), 2);
    step(1);
    i_irq_ack = 1'b0;
    check("irq_ack2_clr", 32'(o_irq), 0);

    // Compare line beyond the raster never fires
    i_irq_line = 4'd7;
    irq_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      step(1);
      if (o_irq) irq_cnt++;
    end
    check("irq_oob_cnt", 32'(irq_cnt), 0);
    check("oob_xy", 32'({o_x, o_y}), 32'({4'd5, 4'd3}));
    check("oob_fc", 32'(o_frame_count), 5);

    // Frame counter wrap
    step(19);
    check("fc6_fs", 32'(o_frame_start), 1);
    check("fc6", 32'(o_frame_count), 6);
    step(249 * 48);
    check("fc255_fs", 32'(o_frame_start), 1);
    check("fc255", 32'(o_frame_count), 255);
    step(48);
    check("fc_wrap_fs", 32'(o_frame_start), 1);
    check("fc_wrap", 32'(o_frame_count), 0);
    check("fc_wrap_xy", 32'({o_x, o_y}), 0);

    // Asynchronous reset mid-frame at (3,1) with an interrupt pending
    i_irq_line = 4'd1;
    step(11);
    check("pre_rst_xy", 32'({o_x, o_y}), 32'({4'd3, 4'd1}));
    check("pre_rst_irq", 32'(o_irq), 1);
    check("pre_rst_de", 32'(o_de), 1);
    #2 reset = 1'b1;
    #1 check_reset_values("async");
    step(1);
    reset = 1'b0;
    step(1);
    check("rel_xy", 32'({o_x, o_y}), 0);
    check("rel_fs", 32'(o_frame_start), 1);
    check("rel_ls", 32'(o_line_start), 1);
    check("rel_fc", 32'(o_frame_count), 1);
    check("rel_irq", 32'(o_irq), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
